// File: rtl/fir_bank_out_serializer.sv
// rtl/fir_bank_out_serializer.sv - Double-buffered 8-channel frame to valid/ready word serializer
//
// Ports:
//   clock, reset          rising-edge clock, asynchronous active-low reset
//   frame_valid, ch0..ch7 one-cycle frame strobe with eight signed channel samples
//   m_data, m_chan,       serialized sample, its channel index, last-of-frame marker
//   m_last, m_valid,      and stream handshake (word moves when m_valid && m_ready)
//   m_ready
//   overrun               sticky: a frame arrived with both buffers full and was dropped
//   clear_overrun         clears overrun (a simultaneous drop wins)
//   busy                  m_valid or a pending frame is held
module fir_bank_out_serializer #(
    parameter int DW  = 16,
    parameter int NCH = 8,
    parameter int CHW = 3
) (
    input  logic           clock,
    input  logic           reset,
    input  logic           frame_valid,
    input  logic [DW-1:0]  ch0,
    input  logic [DW-1:0]  ch1,
    input  logic [DW-1:0]  ch2,
    input  logic [DW-1:0]  ch3,
    input  logic [DW-1:0]  ch4,
    input  logic [DW-1:0]  ch5,
    input  logic [DW-1:0]  ch6,
    input  logic [DW-1:0]  ch7,
    output logic [DW-1:0]  m_data,
    output logic [CHW-1:0] m_chan,
    output logic           m_last,
    output logic           m_valid,
    input  logic           m_ready,
    output logic           overrun,
    input  logic           clear_overrun,
    output logic           busy
);

    typedef enum logic {IDLE, SEND} state_t;

    logic [DW-1:0] ch_w   [NCH];
    logic [DW-1:0] act_q  [NCH];
    logic [DW-1:0] act_n  [NCH];
    logic [DW-1:0] pend_q [NCH];
    logic [DW-1:0] pend_n [NCH];

    state_t         state_q, state_n;
    logic [CHW-1:0] idx_q, idx_n, idx_inc;
    logic           pend_full_q, pend_full_n;
    logic [DW-1:0]  m_data_n;
    logic [CHW-1:0] m_chan_n;
    logic           m_last_n, m_valid_n, overrun_n, busy_n;
    logic           xfer, ovr_set;

    assign ch_w[0] = ch0;
    assign ch_w[1] = ch1;
    assign ch_w[2] = ch2;
    assign ch_w[3] = ch3;
    assign ch_w[4] = ch4;
    assign ch_w[5] = ch5;
    assign ch_w[6] = ch6;
    assign ch_w[7] = ch7;

    assign xfer    = m_valid && m_ready;
    assign idx_inc = idx_q + CHW'(1);

    always_comb begin
        state_n     = state_q;
        idx_n       = idx_q;
        act_n       = act_q;
        pend_n      = pend_q;
        pend_full_n = pend_full_q;
        m_data_n    = m_data;
        m_chan_n    = m_chan;
        m_last_n    = m_last;
        m_valid_n   = m_valid;
        ovr_set     = 1'b0;

        case (state_q)
            IDLE: begin
                // Pending is always empty here: SEND only exits with it empty.
                if (frame_valid) begin
                    act_n     = ch_w;
                    idx_n     = '0;
                    m_data_n  = ch_w[0];
                    m_chan_n  = '0;
                    m_last_n  = 1'b0;
                    m_valid_n = 1'b1;
                    state_n   = SEND;
                end
            end
            SEND: begin
                if (xfer && idx_q == CHW'(NCH-1)) begin
                    // Last word leaves: refill active with no bubble if anything is waiting.
                    if (pend_full_q) begin
                        act_n    = pend_q;
                        m_data_n = pend_q[0];
                        idx_n    = '0;
                        m_chan_n = '0;
                        m_last_n = 1'b0;
                        if (frame_valid) begin
                            pend_n = ch_w;
                        end else begin
                            pend_full_n = 1'b0;
                        end
                    end else if (frame_valid) begin
                        act_n    = ch_w;
                        m_data_n = ch_w[0];
                        idx_n    = '0;
                        m_chan_n = '0;
                        m_last_n = 1'b0;
                    end else begin
                        m_valid_n = 1'b0;
                        m_last_n  = 1'b0;
                        state_n   = IDLE;
                    end
                end else begin
                    if (xfer) begin
                        idx_n    = idx_inc;
                        m_data_n = act_q[idx_inc];
                        m_chan_n = idx_inc;
                        m_last_n = (idx_inc == CHW'(NCH-1));
                    end
                    if (frame_valid) begin
                        if (!pend_full_q) begin
                            pend_n      = ch_w;
                            pend_full_n = 1'b1;
                        end else begin
                            ovr_set = 1'b1;
                        end
                    end
                end
            end
            default: state_n = IDLE;
        endcase

        overrun_n = ovr_set ? 1'b1 : (clear_overrun ? 1'b0 : overrun);
        busy_n    = m_valid_n || pend_full_n;
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state_q     <= IDLE;
            idx_q       <= '0;
            pend_full_q <= 1'b0;
            m_data      <= '0;
            m_chan      <= '0;
            m_last      <= 1'b0;
            m_valid     <= 1'b0;
            overrun     <= 1'b0;
            busy        <= 1'b0;
            for (int i = 0; i < NCH; i++) begin
                act_q[i]  <= '0;
                pend_q[i] <= '0;
            end
        end else begin
            state_q     <= state_n;
            idx_q       <= idx_n;
            pend_full_q <= pend_full_n;
            m_data      <= m_data_n;
            m_chan      <= m_chan_n;
            m_last      <= m_last_n;
            m_valid     <= m_valid_n;
            overrun     <= overrun_n;
            busy        <= busy_n;
            act_q       <= act_n;
            pend_q      <= pend_n;
        end
    end

endmodule

// File: tb/tb_fir_bank_out_serializer.sv
// tb/tb_fir_bank_out_serializer.sv - Self-checking bench for fir_bank_out_serializer
module tb_fir_bank_out_serializer;

    localparam int DW  = 16;
    localparam int NCH = 8;
    localparam int CHW = 3;

    logic           clock = 1'b0;
    logic           reset;
    logic           frame_valid;
    logic [DW-1:0]  ch [NCH];
    logic [DW-1:0]  m_data;
    logic [CHW-1:0] m_chan;
    logic           m_last, m_valid, m_ready, overrun, clear_overrun, busy;

    fir_bank_out_serializer #(.DW(DW), .NCH(NCH), .CHW(CHW)) dut (
        .clock(clock), .reset(reset), .frame_valid(frame_valid),
        .ch0(ch[0]), .ch1(ch[1]), .ch2(ch[2]), .ch3(ch[3]),
        .ch4(ch[4]), .ch5(ch[5]), .ch6(ch[6]), .ch7(ch[7]),
        .m_data(m_data), .m_chan(m_chan), .m_last(m_last), .m_valid(m_valid),
        .m_ready(m_ready), .overrun(overrun), .clear_overrun(clear_overrun), .busy(busy)
    );

    always #5 clock = ~clock;

    int checks = 0;
    int errors = 0;

    // Reference model: a queue of whole frames (front = the one being sent)
    // and a word position within the front frame.
    logic [NCH*DW-1:0] fq [$];
    int                pos = 0;
    logic              ovr_m = 1'b0;
    int                words_out = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic logic [NCH*DW-1:0] pack_frame();
        logic [NCH*DW-1:0] f;
        for (int i = 0; i < NCH; i++) f[i*DW +: DW] = ch[i];
        return f;
    endfunction

    task automatic model_edge();
        bit set;
        if (fq.size() > 0 && m_ready) begin
            words_out++;
            pos++;
            if (pos == NCH) begin
                void'(fq.pop_front());
                pos = 0;
            end
        end
        set = 1'b0;
        if (frame_valid) begin
            if (fq.size() < 2) fq.push_back(pack_frame());
            else set = 1'b1;
        end
        if (set) ovr_m = 1'b1;
        else if (clear_overrun) ovr_m = 1'b0;
    endtask

    task automatic model_check();
        logic [NCH*DW-1:0] f;
        chk("m_valid", m_valid, fq.size() > 0);
        chk("busy", busy, fq.size() > 0);
        chk("overrun", overrun, ovr_m);
        if (fq.size() > 0) begin
            f = fq[0];
            chk("m_data", m_data, f[pos*DW +: DW]);
            chk("m_chan", m_chan, pos);
            chk("m_last", m_last, pos == NCH-1);
        end
    endtask

    task automatic step();
        @(posedge clock);
        model_edge();
        #1;
        model_check();
    endtask

    task automatic load(input logic [DW-1:0] base);
        for (int i = 0; i < NCH; i++) ch[i] = base + DW'(i);
        frame_valid = 1'b1;
    endtask

    typedef struct {
        bit            fv;
        bit            rdy;
        logic [DW-1:0] base;
        bit            ev;
        logic [DW-1:0] ed;
        logic [CHW-1:0] ec;
        bit            el;
        bit            eb;
    } vec_t;

    vec_t tbl [9];
    int   run, best;

    initial begin
        tbl[0] = '{1'b1, 1'b1, 16'h0001, 1'b1, 16'h0001, 3'd0, 1'b0, 1'b1};
        for (int i = 1; i < 8; i++)
            tbl[i] = '{1'b0, 1'b1, 16'h0000, 1'b1, DW'(i + 1), CHW'(i), (i == 7), 1'b1};
        tbl[8] = '{1'b0, 1'b1, 16'h0000, 1'b0, 16'h0000, 3'd0, 1'b0, 1'b0};

        reset = 1'b0; frame_valid = 1'b0; m_ready = 1'b0; clear_overrun = 1'b0;
        for (int i = 0; i < NCH; i++) ch[i] = '0;
        repeat (2) @(posedge clock);
        #1;
        chk("rst_m_valid", m_valid, 0);
        chk("rst_m_data", m_data, 0);
        chk("rst_m_chan", m_chan, 0);
        chk("rst_m_last", m_last, 0);
        chk("rst_overrun", overrun, 0);
        chk("rst_busy", busy, 0);
        reset = 1'b1;

        // Single frame 0x0001..0x0008 with m_ready high.
        for (int k = 0; k < 9; k++) begin
            m_ready = tbl[k].rdy;
            if (tbl[k].fv) load(tbl[k].base);
            step();
            frame_valid = 1'b0;
            chk("tbl_valid", m_valid, tbl[k].ev);
            chk("tbl_busy", busy, tbl[k].eb);
            if (tbl[k].ev) begin
                chk("tbl_data", m_data, tbl[k].ed);
                chk("tbl_chan", m_chan, tbl[k].ec);
                chk("tbl_last", m_last, tbl[k].el);
            end
        end

        // Same frame with a stalling sink: each word delivered once, stable during stalls.
        words_out = 0;
        m_ready = 1'b1;
        load(16'h0001);
        step();
        frame_valid = 1'b0;
        for (int c = 0; c < 40; c++) begin
            m_ready = (c % 3 == 0);
            step();
        end
        chk("toggle_words", words_out, 8);
        chk("toggle_idle", m_valid, 0);

        // Frame A then B three cycles later: 16 back-to-back words.
        m_ready = 1'b1;
        run = 0; best = 0;
        load(16'h1000);
        step();
        frame_valid = 1'b0;
        for (int c = 0; c < 22; c++) begin
            if (c == 2) load(16'h2000);
            if (m_valid) begin run++; if (run > best) best = run; end
            else run = 0;
            step();
            frame_valid = 1'b0;
        end
        chk("ab_run", best, 16);
        chk("ab_overrun", overrun, 0);

        // Stalled sink: A active, B pending, C dropped.
        m_ready = 1'b0;
        load(16'h1000); step();
        load(16'h2000); step();
        load(16'h3000); step();
        frame_valid = 1'b0;
        chk("c_overrun", overrun, 1);
        words_out = 0;
        m_ready = 1'b1;
        repeat (20) step();
        chk("ab_words", words_out, 16);
        chk("ovr_sticky", overrun, 1);
        clear_overrun = 1'b1; step(); clear_overrun = 1'b0;
        chk("ovr_clear", overrun, 0);

        // New frame coincident with the chan-7 transfer, pending empty.
        load(16'h4000); step(); frame_valid = 1'b0;
        repeat (7) step();
        chk("pre_last", m_last, 1);
        load(16'h5000); step(); frame_valid = 1'b0;
        chk("coin_valid", m_valid, 1);
        chk("coin_chan", m_chan, 0);
        chk("coin_data", m_data, 16'h5000);
        repeat (10) step();

        // Reset mid-frame after chan 3 has gone.
        load(16'h6000); step(); frame_valid = 1'b0;
        load(16'h7000); step(); frame_valid = 1'b0;
        repeat (3) step();
        #2 reset = 1'b0;
        #1;
        chk("arst_valid", m_valid, 0);
        chk("arst_data", m_data, 0);
        chk("arst_chan", m_chan, 0);
        chk("arst_last", m_last, 0);
        chk("arst_busy", busy, 0);
        fq.delete(); pos = 0; ovr_m = 1'b0;
        @(negedge clock) reset = 1'b1;
        repeat (4) step();
        chk("post_rst_valid", m_valid, 0);

        // Randomized traffic against the model.
        for (int c = 0; c < 600; c++) begin
            m_ready = ($urandom_range(0, 3) != 0);
            clear_overrun = ($urandom_range(0, 9) == 0);
            if ($urandom_range(0, 5) == 0) begin
                for (int i = 0; i < NCH; i++) ch[i] = DW'($urandom);
                frame_valid = 1'b1;
            end
            step();
            frame_valid = 1'b0;
            clear_overrun = 1'b0;
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/fir_bank_out_serializer.md
Name: fir_bank_out_serializer

Overview:
- Downstream stage of the 8-channel FIR filter bank.
- Captures all eight 16-bit channel results on a frame strobe and serializes them as one channel word per transfer over a valid/ready stream, channels 0..7 in order.
- Double-buffered: one active frame being sent plus one pending frame, so the bank can deliver the next frame while the current one drains.
- Frames that cannot be buffered are dropped and flagged.

Parameters:
- DW, 16, width of each channel sample and of m_data.
- NCH, 8, number of channels per frame. Fixed at 8 for this revision.
- CHW, 3, width of the channel index (log2 NCH).

Ports:
- clock  in  1  system clock, rising edge.
- reset  in  1  asynchronous, active-low reset.
- frame_valid  in  1  one-cycle strobe; ch0..ch7 are valid in this cycle.
- ch0..ch7  in  DW each  signed filter-bank outputs, sampled only when frame_valid=1.
- m_data  out  DW  serialized sample.
- m_chan  out  CHW  channel index of m_data.
- m_last  out  1  high with channel NCH-1 of a frame.
- m_valid  out  1  output word valid.
- m_ready  in  1  sink accepts the word this cycle.
- overrun  out  1  sticky flag: a frame was dropped.
- clear_overrun  in  1  clears overrun.
- busy  out  1  m_valid OR pending frame held.

Behaviour:
- Reset (async assert, sync release) sets:
  - m_valid=0, m_data=0, m_chan=0, m_last=0, overrun=0, busy=0.
  - pending slot empty, both frame registers zero, FSM in IDLE.
- Asserting reset mid-frame discards the active and pending frames. No partial words are emitted after release.
- Transfer occurs when m_valid=1 and m_ready=1.
- While m_valid=1 and m_ready=0, m_data, m_chan and m_last hold stable.
- m_valid never drops without a transfer except on reset.
- All outputs are registered.
- FSM has two states, IDLE and SEND.
- IDLE:
  - frame_valid at cycle N loads the active frame and sets idx=0.
  - Go to SEND. m_valid=1 with chan 0 at cycle N+1 (latency 1).
- SEND, normal advance:
  - On a transfer with idx<7: idx+1; next word presented the following cycle.
  - m_chan=idx; m_last=(idx==7).
- SEND, transfer of idx 7:
  - If the pending slot is full: pending moves to active, idx=0, stay SEND. Chan 0 of the next frame follows with no bubble and pending becomes empty.
  - Else, if frame_valid is high in the same cycle: the new frame loads directly into active, idx=0, stay SEND.
  - Else: go to IDLE, m_valid=0.
- SEND, frame_valid not coinciding with the last transfer:
  - Pending empty: store into pending.
  - Pending full: drop the new frame and set overrun. Pending keeps the older frame.
- frame_valid coinciding with the last transfer while pending is full:
  - Pending moves to active and the new frame moves to pending.
  - No overrun.
- overrun:
  - Set dominates clear when both occur in the same cycle.
  - Otherwise clear_overrun=1 clears it on the next edge.
- Data is passed bit-exact. No arithmetic, rounding or saturation.
- Peak throughput is one word per cycle; a frame takes 8 cycles with m_ready held high.
- Sustained input rate must be ≤1 frame per 8 cycles, or overrun occurs.

Test Plan:
- Reset, then one frame ch0..ch7 = 0x0001..0x0008, m_ready=1:
  - m_valid rises 1 cycle after frame_valid.
  - 8 consecutive words 0x0001..0x0008, chan 0..7, m_last only on chan 7.
  - Then m_valid=0 and busy=0.
- Same frame with m_ready toggling 1,0,0,1,...: every word is delivered once in order, and data is stable during stalls.
- Frame A (0x1000+i), then frame B (0x2000+i) 3 cycles later, m_ready=1:
  - 16 words with no gap between A chan 7 and B chan 0.
  - overrun stays 0.
- m_ready=0 after frame A; send frames B and C:
  - C is dropped and overrun=1.
  - After m_ready=1, output is A then B only.
  - clear_overrun pulse returns overrun to 0.
- frame_valid coincident with the chan-7 transfer, pending empty: the new frame's chan 0 is presented the next cycle with no IDLE gap.
- Assert reset mid-frame (after chan 3): all outputs go to 0 immediately (async). After release, m_valid stays 0 until the next frame_valid.
